// File: rtl/avr_dm_xsram_slv_pkg.sv
// Shared definitions for the external-SRAM DM slave: bus slice layout and FSM state encoding.
package avr_dm_xsram_slv_pkg;

   localparam int SLV_W      = 10;
   localparam int OUT_EN_BIT = 9;
   localparam int WAIT_BIT   = 8;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RD      = 3'd1,
      ST_RD_DONE = 3'd2,
      ST_WR      = 3'd3,
      ST_WR_DONE = 3'd4
   } xsram_state_e;

   function automatic logic [SLV_W-1:0] pack_slv(input logic       out_en,
                                                 input logic       stall,
                                                 input logic [7:0] data);
      logic [SLV_W-1:0] s;
      s             = '0;
      s[OUT_EN_BIT] = out_en;
      s[WAIT_BIT]   = stall;
      s[7:0]        = data;
      return s;
   endfunction

endpackage

// File: rtl/avr_dm_xsram_slv_ws_cnt.sv
// 4-bit wait-state counter: parallel load, decrement-to-zero, combinational zero flag.
module avr_dm_ws_cnt (
   input  logic       cp2,
   input  logic       ireset,
   input  logic       load_i,
   input  logic       dec_i,
   input  logic [3:0] load_val_i,
   output logic       zero_o
);

   logic [3:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i)
         cnt_d = load_val_i;
      else if (dec_i && (cnt_q != 4'd0))
         cnt_d = cnt_q - 4'd1;
   end

   always_ff @(posedge cp2 or negedge ireset) begin
      if (!ireset)
         cnt_q <= 4'd0;
      else
         cnt_q <= cnt_d;
   end

   assign zero_o = (cnt_q == 4'd0);

endmodule

// File: rtl/avr_dm_xsram_slv.sv
// DM-bus slave bridging AVR data-memory cycles to an asynchronous external SRAM with wait states.
// Optional AVR_DM_XSRAM_POSTED_WR_EN: writes are posted (no wait) and finish in the background.
module avr_dm_xsram_slv
   import avr_dm_xsram_slv_pkg::*;
#(
   parameter int ADR_W = 15,
   parameter int RD_WS = 2,
   parameter int WR_WS = 2
) (
   input  logic             cp2,
   input  logic             ireset,
   input  logic             sel,
   input  logic [15:0]      ramadr,
   input  logic [7:0]       ramdout,
   input  logic             ramre,
   input  logic             ramwe,
   output logic [SLV_W-1:0] slv_out,
   output logic [ADR_W-1:0] xm_adr,
   output logic [7:0]       xm_dout,
   output logic             xm_dout_en,
   input  logic [7:0]       xm_din,
   output logic             xm_ce_n,
   output logic             xm_oe_n,
   output logic             xm_we_n
);

   xsram_state_e     state_q;
   logic [ADR_W-1:0] adr_q;
   logic [7:0]       dout_q;
   logic [7:0]       rd_data_q;
   logic             ce_n_q, oe_n_q, we_n_q, dout_en_q;
`ifdef AVR_DM_XSRAM_POSTED_WR_EN
   logic             posted_q;
`endif

   logic       req;
   logic       stall;
   logic       out_en;
   logic       cnt_load, cnt_dec, cnt_zero;
   logic [3:0] cnt_init;

   assign req = sel & (ramre | ramwe);

   assign cnt_load = (state_q == ST_IDLE) & req;
   assign cnt_dec  = ((state_q == ST_RD) | (state_q == ST_WR)) & ~cnt_zero;
   assign cnt_init = ramwe ? 4'(WR_WS - 1) : 4'(RD_WS - 1);

   avr_dm_ws_cnt u_ws_cnt (
      .cp2        (cp2),
      .ireset     (ireset),
      .load_i     (cnt_load),
      .dec_i      (cnt_dec),
      .load_val_i (cnt_init),
      .zero_o     (cnt_zero)
   );

   // wait is seen by the interconnect in the same cycle, so it cannot be registered
   always_comb begin
      stall = 1'b0;
      unique case (state_q)
`ifdef AVR_DM_XSRAM_POSTED_WR_EN
         ST_IDLE:      stall = req & ~ramwe;
`else
         ST_IDLE:      stall = req;
`endif
         ST_RD, ST_WR: stall = sel;
         default:      stall = 1'b0;
      endcase
`ifdef AVR_DM_XSRAM_POSTED_WR_EN
      if (posted_q)
         stall = req;
`endif
   end

   assign out_en  = (state_q == ST_RD_DONE) & sel & ramre;
   assign slv_out = ireset ? pack_slv(out_en, stall,
                                      (state_q == ST_RD_DONE) ? rd_data_q : 8'h00)
                           : '0;

   always_ff @(posedge cp2 or negedge ireset) begin
      if (!ireset) begin
         state_q   <= ST_IDLE;
         adr_q     <= '0;
         dout_q    <= 8'h00;
         rd_data_q <= 8'h00;
         ce_n_q    <= 1'b1;
         oe_n_q    <= 1'b1;
         we_n_q    <= 1'b1;
         dout_en_q <= 1'b0;
`ifdef AVR_DM_XSRAM_POSTED_WR_EN
         posted_q  <= 1'b0;
`endif
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (req) begin
                  adr_q  <= ramadr[ADR_W-1:0];
                  dout_q <= ramdout;
                  ce_n_q <= 1'b0;
                  if (ramwe) begin
                     state_q   <= ST_WR;
                     we_n_q    <= 1'b0;
                     dout_en_q <= 1'b1;
`ifdef AVR_DM_XSRAM_POSTED_WR_EN
                     posted_q  <= 1'b1;
`endif
                  end else begin
                     state_q <= ST_RD;
                     oe_n_q  <= 1'b0;
                  end
               end
            end
            ST_RD: begin
               if (cnt_zero) begin
                  rd_data_q <= xm_din;
                  state_q   <= ST_RD_DONE;
                  ce_n_q    <= 1'b1;
                  oe_n_q    <= 1'b1;
               end
            end
            ST_RD_DONE: state_q <= ST_IDLE;
            ST_WR: begin
               // strobe ends first; chip enable and data stay for one hold cycle
               if (cnt_zero) begin
                  state_q <= ST_WR_DONE;
                  we_n_q  <= 1'b1;
               end
            end
            ST_WR_DONE: begin
               state_q   <= ST_IDLE;
               ce_n_q    <= 1'b1;
               dout_en_q <= 1'b0;
`ifdef AVR_DM_XSRAM_POSTED_WR_EN
               posted_q  <= 1'b0;
`endif
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign xm_adr     = adr_q;
   assign xm_dout    = dout_q;
   assign xm_ce_n    = ce_n_q;
   assign xm_oe_n    = oe_n_q;
   assign xm_we_n    = we_n_q;
   assign xm_dout_en = dout_en_q;

   generate
      if (ADR_W < 16) begin : g_unused_adr
         logic unused_adr_hi;
         assign unused_adr_hi = ^ramadr[15:ADR_W];
      end
   endgenerate

endmodule

// File: tb/tb_avr_dm_xsram_slv.sv
// Scoreboard bench for avr_dm_xsram_slv: random DM traffic against a bench SRAM and a reference memory.
module tb_avr_dm_xsram_slv;

   localparam int ADR_W = 15;
   localparam int RD_WS = 2;
   localparam int WR_WS = 2;
`ifdef AVR_DM_XSRAM_POSTED_WR_EN
   localparam bit POSTED = 1'b1;
`else
   localparam bit POSTED = 1'b0;
`endif

   logic             cp2 = 1'b0;
   logic             ireset;
   logic             sel;
   logic [15:0]      ramadr;
   logic [7:0]       ramdout;
   logic             ramre, ramwe;
   logic [9:0]       slv_out;
   logic [ADR_W-1:0] xm_adr;
   logic [7:0]       xm_dout;
   logic             xm_dout_en;
   logic [7:0]       xm_din;
   logic             xm_ce_n, xm_oe_n, xm_we_n;

   avr_dm_xsram_slv #(.ADR_W(ADR_W), .RD_WS(RD_WS), .WR_WS(WR_WS)) dut (
      .cp2(cp2), .ireset(ireset), .sel(sel), .ramadr(ramadr), .ramdout(ramdout),
      .ramre(ramre), .ramwe(ramwe), .slv_out(slv_out), .xm_adr(xm_adr),
      .xm_dout(xm_dout), .xm_dout_en(xm_dout_en), .xm_din(xm_din),
      .xm_ce_n(xm_ce_n), .xm_oe_n(xm_oe_n), .xm_we_n(xm_we_n)
   );

   always #5 cp2 = ~cp2;

   typedef struct {
      bit          is_rd;
      logic [14:0] adr;
      logic [7:0]  data;
      int          waits;
   } exp_t;
   typedef struct {
      logic [14:0] adr;
      logic [7:0]  data;
   } wr_t;

   exp_t exp_q[$];
   wr_t  wr_q[$];
   logic [7:0] sram_mem [0:32767];
   logic [7:0] ref_mem  [0:32767];

   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   busy_until = 0;
   int   txn = 0;
   bit   mon_en = 1'b0;

   assign xm_din = (!xm_oe_n && !xm_ce_n) ? sram_mem[xm_adr] : 8'hEE;

   always @(posedge cp2) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Response monitor: a request completes in the cycle it sees wait low
   int   wcnt = 0;
   exp_t mon_e;
   always @(negedge cp2) begin
      if (!ireset || !mon_en) begin
         wcnt = 0;
      end else if (sel && (ramre || ramwe)) begin
         if (slv_out[8]) begin
            wcnt++;
         end else if (exp_q.size() == 0) begin
            chk("unexpected_completion", 1, 0);
         end else begin
            mon_e = exp_q.pop_front();
            txn++;
            $display("txn %0d %s adr=%h data=%h waits=%0d slv_out=%h", txn,
                     mon_e.is_rd ? "RD" : "WR", mon_e.adr, mon_e.data, wcnt, slv_out);
            chk("wait_cycles", wcnt, mon_e.waits);
            chk("slv_out", slv_out, {mon_e.is_rd, 1'b0, mon_e.is_rd ? mon_e.data : 8'h00});
            wcnt = 0;
         end
      end
   end

   // SRAM pin model: latch data at the end of each write strobe and check the strobe
   int  we_cnt = 0;
   bit  prev_we = 1'b1;
   wr_t wr_e;
   always @(negedge cp2) begin
      if (!ireset) begin
         we_cnt  = 0;
         prev_we = 1'b1;
      end else begin
         if (!xm_we_n) begin
            we_cnt++;
         end else if (!prev_we) begin
            if (!xm_ce_n) sram_mem[xm_adr] = xm_dout;
            if (wr_q.size() == 0) begin
               chk("unexpected_write_strobe", 1, 0);
            end else begin
               wr_e = wr_q.pop_front();
               chk("we_low_cycles", we_cnt, WR_WS);
               chk("write_pins", {xm_ce_n, xm_dout_en, 1'b0, xm_adr, xm_dout},
                   {1'b0, 1'b1, 1'b0, wr_e.adr, wr_e.data});
            end
            we_cnt = 0;
         end
         prev_we = xm_we_n;
      end
   end

   // Present one access just after a rising edge; hold it until wait drops
   task automatic access(input bit wr, input bit rd, input logic [15:0] a, input logic [7:0] d);
      exp_t e;
      int   extra;
      int   n;
      extra = busy_until - cyc;
      if (extra < 0) extra = 0;
      e.is_rd = rd && !wr;
      e.adr   = a[14:0];
      if (wr) begin
         ref_mem[a[14:0]] = d;
         e.data  = d;
         e.waits = extra + (POSTED ? 0 : WR_WS + 1);
         wr_q.push_back('{adr: a[14:0], data: d});
         if (POSTED) busy_until = cyc + extra + WR_WS + 2;
      end else begin
         e.data  = ref_mem[a[14:0]];
         e.waits = extra + RD_WS + 1;
      end
      exp_q.push_back(e);
      sel = 1'b1; ramadr = a; ramdout = d; ramre = rd; ramwe = wr;
      n = 0;
      @(negedge cp2);
      while (slv_out[8] && n < 200) begin
         n++;
         @(negedge cp2);
      end
      if (n >= 200) begin
         errors++; checks++;
         $display("FAIL access_timeout: got wait=1 after %0d cycles required wait=0", n);
      end
      @(posedge cp2); #1;
      sel = 1'b0; ramre = 1'b0; ramwe = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge cp2); #1;
      end
   endtask

   logic [15:0] pool [8];
   int          r;

   initial begin
      ireset = 1'b0; sel = 1'b0; ramadr = 16'h0; ramdout = 8'h0; ramre = 1'b0; ramwe = 1'b0;
      for (int i = 0; i < 32768; i++) begin
         sram_mem[i] = 8'($urandom);
         ref_mem[i]  = sram_mem[i];
      end
      sram_mem[15'h1234] = 8'hA5;
      ref_mem[15'h1234]  = 8'hA5;

      #12;
      chk("reset_slv_out", slv_out, 0);
      chk("reset_strobes", {xm_ce_n, xm_oe_n, xm_we_n, xm_dout_en}, 4'b1110);
      chk("reset_adr_dout", {xm_adr, xm_dout}, 0);
      ramre = 1'b1; sel = 1'b1;
      #1;
      chk("reset_slv_out_req", slv_out, 0);
      ramre = 1'b0; sel = 1'b0;
      #9;
      ireset = 1'b1;
      mon_en = 1'b1;
      idle(1);

      access(1'b0, 1'b1, 16'h1234, 8'h00);
      access(1'b1, 1'b0, 16'h1001, 8'h5A);
      idle(1);
      access(1'b0, 1'b1, 16'h1001, 8'h00);

      sel = 1'b0; ramre = 1'b1; ramadr = 16'h0077;
      for (int i = 0; i < 4; i++) begin
         @(negedge cp2);
         chk("sel0_no_activity", {slv_out, xm_ce_n, xm_oe_n, xm_we_n}, {10'h0, 3'b111});
      end
      @(posedge cp2); #1;
      ramre = 1'b0;

      access(1'b1, 1'b1, 16'h0042, 8'h3C);
      access(1'b0, 1'b1, 16'h0042, 8'h00);

      access(1'b1, 1'b0, 16'h0200, 8'h77);
      access(1'b0, 1'b1, 16'h0200, 8'h00);
      idle(1);

      for (int i = 0; i < 8; i++) pool[i] = 16'($urandom);
      for (int i = 0; i < 60; i++) begin
         r = $urandom_range(0, 9);
         if (r < 5)      access(1'b0, 1'b1, pool[$urandom_range(0, 7)], 8'($urandom));
         else if (r < 9) access(1'b1, 1'b0, pool[$urandom_range(0, 7)], 8'($urandom));
         else            access(1'b1, 1'b1, pool[$urandom_range(0, 7)], 8'($urandom));
         idle($urandom_range(0, 2));
      end
      idle(8);

      mon_en = 1'b0;
      sel = 1'b1; ramadr = 16'h1234; ramre = 1'b1;
      @(posedge cp2); #3;
      ireset = 1'b0;
      #1;
      chk("abort_slv_out", slv_out, 0);
      chk("abort_pins", {xm_ce_n, xm_oe_n, xm_we_n, xm_dout_en}, 4'b1110);
      sel = 1'b0; ramre = 1'b0;
      @(posedge cp2); #2;
      ireset = 1'b1;
      busy_until = 0;
      @(posedge cp2); #1;
      mon_en = 1'b1;
      access(1'b0, 1'b1, 16'h1234, 8'h00);
      idle(8);

      chk("exp_q_drained", exp_q.size(), 0);
      chk("wr_q_drained", wr_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
